// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-file
// address width, FSM state encoding, default counter width and the
// source/destination match helper.
package hazard_ctrl_pkg;

  localparam int unsigned REG_FILE_ADDR_LEN = 5;
  localparam int unsigned CNT_W_DEFAULT     = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_t;

  // True when the ID instruction reads a nonzero destination register.
  function automatic logic src_match(
    input logic [REG_FILE_ADDR_LEN-1:0] src1,
    input logic [REG_FILE_ADDR_LEN-1:0] src2,
    input logic                         two_src,
    input logic [REG_FILE_ADDR_LEN-1:0] dest
  );
    return (dest != '0) && ((src1 == dest) || (two_src && (src2 == dest)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on each enabled cycle, sticks at all-ones.
module sat_counter
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Count enabled cycles, holding at the maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stall detection, taken-branch
// flush, data-memory freeze with timeout, and saturating event counters.
// Optional build macro HAZARD_FORWARDING_EN: with forwarding present only a
// load in EXE can cause a stall; without it any pending write in EXE or MEM
// to a register read in ID stalls until it retires.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       src1_ID,
  input  logic [4:0]       src2_ID,
  input  logic             two_src_ID,
  input  logic [4:0]       dest_EXE,
  input  logic [4:0]       dest_MEM,
  input  logic             WB_EN_EXE,
  input  logic             WB_EN_MEM,
  input  logic             MEM_R_EN_EXE,
  input  logic             br_taken_EXE,
  input  logic             mem_ready,
  output logic             stall_IF_ID,
  output logic             bubble_ID_EXE,
  output logic             flush_IF_ID,
  output logic             flush_ID_EXE,
  output logic             freeze_all,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             err_timeout
);

  // MEM_TIMEOUT is expected to be at least 1.
  localparam int unsigned   TW        = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(MEM_TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] wait_q;
  logic          err_q;
  logic          hazard;

`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers ALU results; only a load in EXE forces one bubble.
  assign hazard = MEM_R_EN_EXE & WB_EN_EXE
                & src_match(src1_ID, src2_ID, two_src_ID, dest_EXE);

  logic unused_inputs;
  assign unused_inputs = ^{dest_MEM, WB_EN_MEM};
`else
  // No forwarding: any pending write in EXE or MEM blocks the reader.
  assign hazard = (WB_EN_EXE & src_match(src1_ID, src2_ID, two_src_ID, dest_EXE))
                | (WB_EN_MEM & src_match(src1_ID, src2_ID, two_src_ID, dest_MEM));

  logic unused_inputs;
  assign unused_inputs = MEM_R_EN_EXE;
`endif

  // Control outputs with priority freeze > flush > stall, all low in reset.
  // A branch held in EXE during a freeze flushes on the first ready cycle,
  // which may still be a WAIT-state cycle.
  always_comb begin
    freeze_all    = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EXE  = 1'b0;
    stall_IF_ID   = 1'b0;
    bubble_ID_EXE = 1'b0;
    if (rst) begin
      if (!mem_ready || (state == ERR)) begin
        freeze_all = 1'b1;
      end else if (br_taken_EXE) begin
        flush_IF_ID  = 1'b1;
        flush_ID_EXE = 1'b1;
      end else if (hazard) begin
        stall_IF_ID   = 1'b1;
        bubble_ID_EXE = 1'b1;
      end
    end
  end

  // Memory-wait FSM; ERR is entered after the MEM_TIMEOUT-th WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          wait_q <= '0;
          if (!mem_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state  <= RUN;
            wait_q <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state <= ERR;
            err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state  <= RUN;
          wait_q <= '0;
        end
      endcase
    end
  end

  assign err_timeout = err_q;

  // Event counters.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (stall_IF_ID),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (flush_IF_ID),
    .cnt (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .en  (freeze_all),
    .cnt (wait_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4). Works with or
// without HAZARD_FORWARDING_EN defined.
module tb_hazard_ctrl;

  localparam int unsigned MT   = 4;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [4:0]    src1_ID, src2_ID, dest_EXE, dest_MEM;
  logic          two_src_ID, WB_EN_EXE, WB_EN_MEM, MEM_R_EN_EXE;
  logic          br_taken_EXE, mem_ready;
  logic          stall_IF_ID, bubble_ID_EXE, flush_IF_ID, flush_ID_EXE;
  logic          freeze_all, err_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt, wait_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .src1_ID      (src1_ID),
    .src2_ID      (src2_ID),
    .two_src_ID   (two_src_ID),
    .dest_EXE     (dest_EXE),
    .dest_MEM     (dest_MEM),
    .WB_EN_EXE    (WB_EN_EXE),
    .WB_EN_MEM    (WB_EN_MEM),
    .MEM_R_EN_EXE (MEM_R_EN_EXE),
    .br_taken_EXE (br_taken_EXE),
    .mem_ready    (mem_ready),
    .stall_IF_ID  (stall_IF_ID),
    .bubble_ID_EXE(bubble_ID_EXE),
    .flush_IF_ID  (flush_IF_ID),
    .flush_ID_EXE (flush_ID_EXE),
    .freeze_all   (freeze_all),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .wait_cnt     (wait_cnt),
    .err_timeout  (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int low_run = 0;   // consecutive mem_ready-low cycles seen
  bit err_m   = 1'b0;
  int sc = 0, fc = 0, wc = 0;

  function automatic bit reads(input int d);
    return (int'(src1_ID) == d) || (two_src_ID && (int'(src2_ID) == d));
  endfunction

  function automatic bit exp_hazard();
    bit h = 1'b0;
    int d[2];
    bit en[2];
    d[0] = int'(dest_EXE); en[0] = WB_EN_EXE;
    d[1] = int'(dest_MEM); en[1] = WB_EN_MEM;
    if (FWD) begin
      h = MEM_R_EN_EXE && en[0] && (d[0] != 0) && reads(d[0]);
    end else begin
      for (int i = 0; i < 2; i++)
        if (en[i] && (d[i] != 0) && reads(d[i])) h = 1'b1;
    end
    return h;
  endfunction

  function automatic bit exp_freeze();
    return rst && (!mem_ready || err_m);
  endfunction

  function automatic bit exp_flush();
    return rst && !exp_freeze() && br_taken_EXE;
  endfunction

  function automatic bit exp_stall();
    return rst && !exp_freeze() && !br_taken_EXE && exp_hazard();
  endfunction

  // Model state: counters and the timeout, evolved from the rules.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_run <= 0;
      err_m   <= 1'b0;
      sc <= 0; fc <= 0; wc <= 0;
    end else begin
      if (exp_stall()  && sc < CMAX) sc <= sc + 1;
      if (exp_flush()  && fc < CMAX) fc <= fc + 1;
      if (exp_freeze() && wc < CMAX) wc <= wc + 1;
      // one RUN cycle detects the stall, then MT WAIT cycles before ERR
      if (!mem_ready && (low_run + 1 == int'(MT) + 1)) err_m <= 1'b1;
      low_run <= mem_ready ? 0 : low_run + 1;
    end
  end

  // Compare process: every output against the model each mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("freeze_all",    freeze_all,    int'(exp_freeze()));
      chk("flush_IF_ID",   flush_IF_ID,   int'(exp_flush()));
      chk("flush_ID_EXE",  flush_ID_EXE,  int'(exp_flush()));
      chk("stall_IF_ID",   stall_IF_ID,   int'(exp_stall()));
      chk("bubble_ID_EXE", bubble_ID_EXE, int'(exp_stall()));
      chk("stall_cnt",     stall_cnt,     sc);
      chk("flush_cnt",     flush_cnt,     fc);
      chk("wait_cnt",      wait_cnt,      wc);
      chk("err_timeout",   err_timeout,   int'(err_m));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                       input logic [4:0] de, input logic [4:0] dm,
                       input logic we, input logic wm, input logic ld,
                       input logic br, input logic rdy);
    @(posedge clk);
    #1;
    src1_ID = s1; src2_ID = s2; two_src_ID = two;
    dest_EXE = de; dest_MEM = dm; WB_EN_EXE = we; WB_EN_MEM = wm;
    MEM_R_EN_EXE = ld; br_taken_EXE = br; mem_ready = rdy;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    src1_ID = '0; src2_ID = '0; two_src_ID = 1'b0;
    dest_EXE = '0; dest_MEM = '0; WB_EN_EXE = 1'b0; WB_EN_MEM = 1'b0;
    MEM_R_EN_EXE = 1'b0; br_taken_EXE = 1'b1; mem_ready = 1'b0;
    chk_en = 1'b1;

    // Reset: outputs low even with mem_ready=0 and a branch pending.
    #2;
    chk("rst_freeze", freeze_all, 0);
    chk("rst_flush",  flush_IF_ID, 0);
    chk("rst_cnt",    stall_cnt, 0);
    chk("rst_err",    err_timeout, 0);
    @(posedge clk);
    #1;
    br_taken_EXE = 1'b0; mem_ready = 1'b1; rst = 1'b1;

    // RAW hazards through EXE and MEM.
    drive(5'd7, 5'd3, 1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mem_src2_stall",  stall_IF_ID,   FWD ? 0 : 1);
    chk("mem_src2_bubble", bubble_ID_EXE, FWD ? 0 : 1);
    drive(5'd7, 5'd3, 1'b0, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("one_src_stall", stall_IF_ID, 0);
    drive(5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("r0_stall", stall_IF_ID, 0);
    drive(5'd5, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("load_use_stall",  stall_IF_ID,   1);
    chk("load_use_bubble", bubble_ID_EXE, 1);
    drive(5'd9, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("alu_exe_stall", stall_IF_ID, FWD ? 0 : 1);
    drive(5'd9, 5'd0, 1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("no_wb_stall", stall_IF_ID, 0);
    idle();
    chk("stall_cnt_raw",   stall_cnt, FWD ? 1 : 3);
    chk("model_stall_cnt", sc,        FWD ? 1 : 3);

    // Branch beats a concurrent load-use hazard.
    drive(5'd9, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("br_flush_if", flush_IF_ID,  1);
    chk("br_flush_id", flush_ID_EXE, 1);
    chk("br_stall",    stall_IF_ID,  0);
    idle();
    chk("flush_cnt_br", flush_cnt, 1);
    chk("stall_cnt_br", stall_cnt, FWD ? 1 : 3);

    // Freeze with a branch held in EXE, flush once memory is ready.
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      drive(5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("frz_freeze", freeze_all, 1);
      chk("frz_flush",  flush_IF_ID, 0);
    end
    drive(5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("late_flush",  flush_IF_ID, 1);
    chk("late_freeze", freeze_all, 0);
    idle();
    chk("wait_cnt_3",  wait_cnt, 3);
    chk("model_wc_3",  wc, 3);
    chk("flush_cnt_1", flush_cnt, 1);
    chk("no_err_3",    err_timeout, 0);

    // Timeout: ERR after MT WAIT cycles, stays frozen, reset clears.
    reset_pulse();
    for (int i = 0; i < 5; i++)
      drive(5'd9, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("err_not_yet", err_timeout, 0);
    drive(5'd9, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("err_set",     err_timeout, 1);
    chk("err_freeze",  freeze_all, 1);
    chk("err_flush",   flush_IF_ID, 0);
    chk("err_stall",   stall_IF_ID, 0);
    chk("err_waitcnt", wait_cnt, 5);
    #1 rst = 1'b0;
    #1;
    chk("async_err",    err_timeout, 0);
    chk("async_wait",   wait_cnt, 0);
    chk("async_freeze", freeze_all, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    idle();
    chk("post_err_freeze", freeze_all, 0);

    // Saturation: 20 stall cycles on a 4-bit counter.
    for (int i = 0; i < 20; i++)
      drive(5'd9, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    chk("stall_sat",   stall_cnt, 15);
    idle();
    chk("stall_hold",  stall_cnt, 15);
    chk("model_sat",   sc, 15);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
